// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the digit-serial multiplier.
// Consumed by seq_mult_param; SEQ_MULT_SIGNED_EN selects the two's-complement build there.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam int DIGIT_W_DEF = 4;

    // A single-step operation still needs a one-bit counter.
    function automatic int cnt_width(input int np);
        return (np <= 1) ? 1 : $clog2(np);
    endfunction

endpackage

// File: rtl/seq_mult_param_mult_digit.sv
// Combinational DIGIT_W x DIGIT_W unsigned partial-product generator.
// Operands are widened first so the full double-width product is kept.
module mult_digit #(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0]   a_i,
    input  logic [DIGIT_W-1:0]   b_i,
    output logic [2*DIGIT_W-1:0] p_o
);

    assign p_o = {{DIGIT_W{1'b0}}, a_i} * {{DIGIT_W{1'b0}}, b_i};

endmodule

// File: rtl/seq_mult_param.sv
// Digit-serial multiplier: one DIGIT_W x DIGIT_W partial product per clock, NA*NB steps.
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module seq_mult_param
    import seq_mult_pkg::*;
#(
    parameter int A_WIDTH = 8,
    parameter int B_WIDTH = 8,
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_a,
    input  logic                       start,
    input  logic [A_WIDTH-1:0]         dataa,
    input  logic [B_WIDTH-1:0]         datab,
    output logic [A_WIDTH+B_WIDTH-1:0] product,
    output logic                       done,
    output logic                       busy,
    output logic                       err,
    output logic [1:0]                 state_out
);

    localparam int NA = A_WIDTH / DIGIT_W;
    localparam int NB = B_WIDTH / DIGIT_W;
    localparam int NP = NA * NB;
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam int CW = cnt_width(NP);

    if ((A_WIDTH % DIGIT_W) != 0) begin : g_chk_a
        $error("A_WIDTH must be a multiple of DIGIT_W");
    end
    if ((B_WIDTH % DIGIT_W) != 0) begin : g_chk_b
        $error("B_WIDTH must be a multiple of DIGIT_W");
    end

    state_e               state_q;
    logic [A_WIDTH-1:0]   a_q;
    logic [B_WIDTH-1:0]   b_q;
    logic [PW-1:0]        acc_q;
    logic [PW-1:0]        acc_d;
    logic [PW-1:0]        product_q;
    logic [PW-1:0]        product_d;
    logic [CW-1:0]        cnt_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 err_q;

    logic                 accept;
    logic [A_WIDTH-1:0]   a_in;
    logic [B_WIDTH-1:0]   b_in;
    int                   i_idx;
    int                   j_idx;
    logic [DIGIT_W-1:0]   a_dig;
    logic [DIGIT_W-1:0]   b_dig;
    logic [2*DIGIT_W-1:0] pp;
    logic [PW-1:0]        term;

    // A start in CALC is an abort, not a new request.
    assign accept = start && (state_q != ST_CALC);

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q;

    // |most-negative| = 2^(W-1) still fits in W unsigned bits, so no extra magnitude bit.
    assign a_in      = dataa[A_WIDTH-1] ? (~dataa + A_WIDTH'(1)) : dataa;
    assign b_in      = datab[B_WIDTH-1] ? (~datab + B_WIDTH'(1)) : datab;
    assign product_d = neg_q ? (~acc_d + PW'(1)) : acc_d;

    always_ff @(posedge clk) begin
        if (!reset_a && accept) begin
            neg_q <= dataa[A_WIDTH-1] ^ datab[B_WIDTH-1];
        end
    end
`else
    assign a_in      = dataa;
    assign b_in      = datab;
    assign product_d = acc_d;
`endif

    // Step k walks the multiplicand digits fastest: i = k mod NA, j = k / NA.
    assign i_idx = int'(cnt_q) % NA;
    assign j_idx = int'(cnt_q) / NA;
    assign a_dig = a_q[i_idx*DIGIT_W +: DIGIT_W];
    assign b_dig = b_q[j_idx*DIGIT_W +: DIGIT_W];

    mult_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_mult_digit (
        .a_i (a_dig),
        .b_i (b_dig),
        .p_o (pp)
    );

    assign term  = PW'(pp) << (DIGIT_W * (i_idx + j_idx));
    assign acc_d = acc_q + term;

    always_ff @(posedge clk) begin
        if (!reset_a && accept) begin
            a_q <= a_in;
            b_q <= b_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_q   <= ST_IDLE;
            product_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_CALC: begin
                    if (start) begin
                        state_q <= ST_ERR;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(NP - 1)) begin
                            state_q   <= ST_DONE;
                            product_q <= product_d;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q <= ST_CALC;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                    end else if (state_q == ST_DONE) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign product   = product_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: 8x8 and 16x8 instances against an arithmetic reference.
// Follows SEQ_MULT_SIGNED_EN for the operand interpretation.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        start8, start16;
    logic [7:0]  a8, b8, b16;
    logic [15:0] a16;
    logic [15:0] p8;
    logic [23:0] p16;
    logic        done8, busy8, err8, done16, busy16, err16;
    logic [1:0]  st8, st16;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.A_WIDTH(8), .B_WIDTH(8), .DIGIT_W(4)) u8 (
        .clk(clk), .reset_a(reset_a), .start(start8), .dataa(a8), .datab(b8),
        .product(p8), .done(done8), .busy(busy8), .err(err8), .state_out(st8)
    );

    seq_mult_param #(.A_WIDTH(16), .B_WIDTH(8), .DIGIT_W(4)) u16 (
        .clk(clk), .reset_a(reset_a), .start(start16), .dataa(a16), .datab(b16),
        .product(p16), .done(done16), .busy(busy16), .err(err16), .state_out(st16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[6];

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
        longint r;
`ifdef SEQ_MULT_SIGNED_EN
        r = longint'($signed(a)) * longint'($signed(b));
`else
        r = longint'(a) * longint'(b);
`endif
        return r[15:0];
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Called at the negedge just after the start edge; returns at the done cycle.
    task automatic wait_done8(output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat, output int bcnt);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(lat, bcnt);
    endtask

    initial begin
        int lat, bcnt, ndone;
        logic [15:0] prev, e1, e2;
        logic [7:0] ra, rb;
        logic [23:0] exp16;

        reset_a = 1'b1;
        start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        chk("reset_product", p8, 0);
        chk("reset_done", done8, 0);
        chk("reset_busy", busy8, 0);
        chk("reset_err", err8, 0);
        chk("reset_state", st8, 0);
        chk("reset_product16", p16, 0);
        reset_a = 1'b0;

`ifdef SEQ_MULT_SIGNED_EN
        vt[0] = '{8'hFD, 8'h05, 16'hFFF1};
        vt[1] = '{8'h80, 8'h80, 16'd16384};
        vt[2] = '{8'h7F, 8'h80, 16'hC080};
        vt[3] = '{8'hFF, 8'hFF, 16'd1};
        vt[4] = '{8'h0A, 8'h0B, 16'd110};
        vt[5] = '{8'h80, 8'h01, 16'hFF80};
`else
        vt[0] = '{8'd255, 8'd255, 16'd65025};
        vt[1] = '{8'd0,   8'd77,  16'd0};
        vt[2] = '{8'd1,   8'd200, 16'd200};
        vt[3] = '{8'd16,  8'd16,  16'd256};
        vt[4] = '{8'd170, 8'd85,  16'd14450};
        vt[5] = '{8'd15,  8'd15,  16'd225};
`endif
        for (int i = 0; i < 6; i++) begin
            op8(vt[i].a, vt[i].b, lat, bcnt);
            chk($sformatf("vec%0d_product", i), p8, vt[i].exp);
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
            @(negedge clk);
            chk($sformatf("vec%0d_done_one_cycle", i), done8, 0);
            chk($sformatf("vec%0d_back_idle", i), st8, 0);
        end
        prev = vt[5].exp;

        // Idle with changing operands must not disturb anything.
        a8 = 8'h5A; b8 = 8'hA5;
        repeat (3) @(negedge clk);
        chk("idle_hold_product", p8, prev);
        chk("idle_hold_state", st8, 0);

        // Abort: second start lands on CALC step 2.
        a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        start8 = 1'b1; a8 = 8'd11; b8 = 8'd13;
        @(negedge clk); start8 = 1'b0;
        chk("abort_state", st8, 3);
        chk("abort_err", err8, 1);
        chk("abort_busy", busy8, 0);
        chk("abort_product", p8, prev);
        repeat (3) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("err_hold_state", st8, 3);
        chk("err_hold_product", p8, prev);
        op8(8'd3, 8'd7, lat, bcnt);
        chk("restart_product", p8, 21);
        chk("restart_latency", lat, 4);
        chk("restart_err_clear", err8, 0);
        @(negedge clk);

        // Back-to-back: start asserted only in the DONE cycle.
        ra = 8'($urandom); rb = 8'($urandom);
        e1 = ref8(ra, rb);
        op8(ra, rb, lat, bcnt);
        chk("b2b_first_product", p8, e1);
        ra = 8'($urandom); rb = 8'($urandom);
        e2 = ref8(ra, rb);
        a8 = ra; b8 = rb; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        chk("b2b_reenter_calc", st8, 1);
        chk("b2b_done_low", done8, 0);
        wait_done8(lat, bcnt);
        chk("b2b_done_spacing", lat + 1, 5);
        chk("b2b_second_product", p8, e2);
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            op8(ra, rb, lat, bcnt);
            chk($sformatf("rand%0d_product_%0h_x_%0h", i, ra, rb), p8, ref8(ra, rb));
            chk($sformatf("rand%0d_latency", i), lat, 4);
            @(negedge clk);
        end

        // 16x8 instance: eight steps.
`ifdef SEQ_MULT_SIGNED_EN
        exp16 = 24'hFB6CCE;
`else
        exp16 = 24'h0D6CCE;
`endif
        a16 = 16'hBEEF; b16 = 8'h12; start16 = 1'b1;
        @(negedge clk); start16 = 1'b0;
        lat = 0; bcnt = 0;
        while (!done16 && lat < 40) begin
            if (busy16) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk("w16_product", p16, exp16);
        chk("w16_latency", lat, 8);
        chk("w16_busy_cycles", bcnt, 8);
        @(negedge clk);

        // Reset in the middle of CALC.
        a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        chk("midreset_state", st8, 0);
        chk("midreset_product", p8, 0);
        chk("midreset_busy", busy8, 0);
        ndone = 0;
        repeat (8) begin
            if (done8) ndone++;
            @(negedge clk);
        end
        chk("midreset_no_done", ndone, 0);

        // Reset wins over a simultaneous start.
        reset_a = 1'b1; start8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
        @(negedge clk);
        reset_a = 1'b0; start8 = 1'b0;
        chk("reset_priority_state", st8, 0);
        chk("reset_priority_busy", busy8, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
